mbm_log_converter: RTL and testbench

//  Front-end log stage of the Mitchell-based multiplier (MBM). Accepts an operand pair B1/B2,

---
 rtl/mbm_log_converter.sv | 149 ++++++++++++++
 tb/tb_mbm_log_converter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbm_log_converter.sv
// Log-conversion front end of the Mitchell-based multiplier.
// Captures an operand pair, left-normalises each operand in parallel until its
// leading one reaches the MSB, then emits the summed characteristic and the
// mantissa 1 + x1 + x2 for the antilog barrel shifter.
module mbm_log_converter #(
  parameter int N = 8,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] B1,
  input  logic [N-1:0] B2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] B1_q,
  output logic [N-1:0] B2_q,
  output logic [L-1:0] char_1,
  output logic [L-1:0] char_2,
  output logic         zero_1,
  output logic         zero_2,
  output logic [L:0]   char,
  output logic [N:0]   mantissa
);

  // Every characteristic starts at the MSB position and counts down per shift.
  localparam logic [L-1:0] K_INIT = L'(N - 1);
  localparam logic [L-1:0] K_ONE  = L'(1);
  // Implicit leading one of the mantissa, aligned with the fraction fields.
  localparam logic [N:0]   MANT_ONE = {2'b01, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [N-1:0] sr1;
  logic [N-1:0] sr2;
  logic [L-1:0] k1;
  logic [L-1:0] k2;

  logic         settled_1;
  logic         settled_2;
  logic         both_settled;
  logic [N-2:0] frac_1;
  logic [N-2:0] frac_2;
  logic [L-1:0] char_1_calc;
  logic [L-1:0] char_2_calc;
  logic [L:0]   char_calc;
  logic [N:0]   mantissa_calc;

  // Handshake flags follow directly from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Settle detection and the result values that get latched at the settle edge.
  // A zero operand never finds a leading one, so it contributes nothing.
  always_comb begin
    settled_1     = sr1[N-1] | (sr1 == '0);
    settled_2     = sr2[N-1] | (sr2 == '0);
    both_settled  = settled_1 & settled_2;
    frac_1        = zero_1 ? '0 : sr1[N-2:0];
    frac_2        = zero_2 ? '0 : sr2[N-2:0];
    char_1_calc   = zero_1 ? '0 : k1;
    char_2_calc   = zero_2 ? '0 : k2;
    char_calc     = {1'b0, char_1_calc} + {1'b0, char_2_calc};
    mantissa_calc = MANT_ONE + {2'b00, frac_1} + {2'b00, frac_2};
  end

  // State register; reset aborts any pair in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one pair in flight, accept only from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)     state_next = SHIFT;
      SHIFT:   if (both_settled) state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, normalise while shifting, latch results on settle.
  // Outputs are only written at the settle edge so they hold through DONE and
  // keep their last values after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr1      <= '0;
      sr2      <= '0;
      k1       <= '0;
      k2       <= '0;
      B1_q     <= '0;
      B2_q     <= '0;
      zero_1   <= 1'b0;
      zero_2   <= 1'b0;
      char_1   <= '0;
      char_2   <= '0;
      char     <= '0;
      mantissa <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr1    <= B1;
            sr2    <= B2;
            k1     <= K_INIT;
            k2     <= K_INIT;
            B1_q   <= B1;
            B2_q   <= B2;
            zero_1 <= (B1 == '0);
            zero_2 <= (B2 == '0);
          end
        end
        SHIFT: begin
          if (both_settled) begin
            char_1   <= char_1_calc;
            char_2   <= char_2_calc;
            char     <= char_calc;
            mantissa <= mantissa_calc;
          end else begin
            if (!settled_1) begin
              sr1 <= sr1 << 1;
              k1  <= k1 - K_ONE;
            end
            if (!settled_2) begin
              sr2 <= sr2 << 1;
              k2  <= k2 - K_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbm_log_converter.sv
// Self-checking bench for mbm_log_converter: directed corner cases, randomized
// pairs against an arithmetic reference model, back-pressure and reset abort.
module tb_mbm_log_converter;

  localparam int N = 8;
  localparam int L = 3;
  localparam int MAX_WAIT = N + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] B1 = '0;
  logic [N-1:0] B2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] B1_q;
  logic [N-1:0] B2_q;
  logic [L-1:0] char_1;
  logic [L-1:0] char_2;
  logic         zero_1;
  logic         zero_2;
  logic [L:0]   char;
  logic [N:0]   mantissa;

  int checks = 0;
  int errors = 0;

  mbm_log_converter #(.N(N), .L(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .B1(B1), .B2(B2),
    .out_valid(out_valid), .out_ready(out_ready),
    .B1_q(B1_q), .B2_q(B2_q),
    .char_1(char_1), .char_2(char_2),
    .zero_1(zero_1), .zero_2(zero_2),
    .char(char), .mantissa(mantissa)
  );

  always #5 clk = ~clk;

  // Reference: leading-one index k, and the bits below it left-aligned to N-1 bits.
  function automatic void ref_operand(input int b, output int k, output int frac, output int shifts);
    k = 0; frac = 0; shifts = 0;
    if (b != 0) begin
      for (int i = 0; i < N; i++) if (((b >> i) & 1) == 1) k = i;
      frac   = (b - (1 << k)) << (N - 1 - k);
      shifts = N - 1 - k;
    end
  endfunction

  // Present a pair at posedge+1, let it be accepted, then wait for out_valid.
  // Returns the number of edges after the accept edge, or -1 on timeout.
  task automatic send_pair(input logic [N-1:0] b1, input logic [N-1:0] b2, output int lat);
    B1 = b1; B2 = b2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    B1 = N'($urandom); B2 = N'($urandom);
    lat = -1;
    for (int j = 1; j <= MAX_WAIT; j++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = j; break; end
    end
  endtask

  // Complete the output handshake; returns aligned at posedge+1 in IDLE.
  task automatic finish_pair();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (char !== '0 || mantissa !== '0 || B1_q !== '0 || zero_1 !== 1'b0 || char_2 !== '0) begin
      errors++; $display("[TB] FAIL reset_data: char=%0d mant=%h B1_q=%h expected 0", char, mantissa, B1_q);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] d_b1 [4] = '{8'h80, 8'h01, 8'hFF, 8'h00};
    logic [N-1:0] d_b2 [4] = '{8'h80, 8'hC0, 8'hFF, 8'h35};
    int d_lat  [4] = '{1, 8, 1, 3};
    int d_char [4] = '{14, 7, 14, 5};
    int d_mant [4] = '{'h080, 'h0C0, 'h17E, 'h0D4};
    int d_c1   [4] = '{7, 0, 7, 0};
    int d_c2   [4] = '{7, 7, 7, 5};
    int d_z1   [4] = '{0, 0, 0, 1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_pair(d_b1[i], d_b2[i], lat);
      checks++;
      if (lat !== d_lat[i]) begin
        errors++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, d_lat[i]);
      end
      checks++;
      if (int'(char) !== d_char[i] || int'(mantissa) !== d_mant[i]) begin
        errors++; $display("[TB] FAIL dir%0d_result: char=%0d mant=%h expected %0d/%h", i, char, mantissa, d_char[i], d_mant[i]);
      end
      checks++;
      if (int'(char_1) !== d_c1[i] || int'(char_2) !== d_c2[i] || int'(zero_1) !== d_z1[i] || zero_2 !== 1'b0) begin
        errors++; $display("[TB] FAIL dir%0d_fields: c1=%0d c2=%0d z1=%b z2=%b expected %0d/%0d/%0d/0", i, char_1, char_2, zero_1, zero_2, d_c1[i], d_c2[i], d_z1[i]);
      end
      checks++;
      if (B1_q !== d_b1[i] || B2_q !== d_b2[i]) begin
        errors++; $display("[TB] FAIL dir%0d_capture: B1_q=%h B2_q=%h expected %h/%h", i, B1_q, B2_q, d_b1[i], d_b2[i]);
      end
      finish_pair();
    end
  endtask

  function automatic logic [N-1:0] rand_operand();
    int mode = $urandom_range(0, 3);
    logic [N-1:0] v;
    case (mode)
      0:       v = '0;
      1:       v = N'(1 << $urandom_range(0, N - 1));
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [N-1:0] b1, b2;
    int k1, k2, f1, f2, s1, s2, lat, exp_lat, exp_c1, exp_c2, exp_mant;
    for (int i = 0; i < 40; i++) begin
      b1 = rand_operand(); b2 = rand_operand();
      ref_operand(int'(b1), k1, f1, s1);
      ref_operand(int'(b2), k2, f2, s2);
      exp_lat  = 1 + ((s1 > s2) ? s1 : s2);
      exp_c1   = k1; exp_c2 = k2;
      exp_mant = (1 << (N - 1)) + f1 + f2;
      send_pair(b1, b2, lat);
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("[TB] FAIL rnd%0d_latency (%h,%h): got %0d expected %0d", i, b1, b2, lat, exp_lat);
      end
      checks++;
      if (int'(char_1) !== exp_c1 || int'(char_2) !== exp_c2 || int'(char) !== exp_c1 + exp_c2) begin
        errors++; $display("[TB] FAIL rnd%0d_char (%h,%h): got %0d/%0d/%0d expected %0d/%0d/%0d", i, b1, b2, char_1, char_2, char, exp_c1, exp_c2, exp_c1 + exp_c2);
      end
      checks++;
      if (int'(mantissa) !== exp_mant) begin
        errors++; $display("[TB] FAIL rnd%0d_mantissa (%h,%h): got %h expected %h", i, b1, b2, mantissa, exp_mant);
      end
      checks++;
      if (zero_1 !== (b1 == 0) || zero_2 !== (b2 == 0) || B1_q !== b1 || B2_q !== b2) begin
        errors++; $display("[TB] FAIL rnd%0d_capture: z=%b%b q=%h,%h expected %b%b %h,%h", i, zero_1, zero_2, B1_q, B2_q, b1 == 0, b2 == 0, b1, b2);
      end
      finish_pair();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_pair(8'h01, 8'hC0, lat);
    checks++;
    if (lat !== 8) begin
      errors++; $display("[TB] FAIL bp_latency: got %0d expected 8", lat);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; B1 = N'($urandom); B2 = N'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || char !== 4'd7 || mantissa !== 9'h0C0 || B1_q !== 8'h01) begin
        errors++; $display("[TB] FAIL bp_hold%0d: ov=%b ir=%b char=%0d mant=%h B1_q=%h expected 1/0/7/0c0/01", c, out_valid, in_ready, char, mantissa, B1_q);
      end
    end
    in_valid = 1'b0;
    finish_pair();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || char !== 4'd7 || mantissa !== 9'h0C0) begin
      errors++; $display("[TB] FAIL bp_release: ir=%b ov=%b char=%0d mant=%h expected 1/0/7/0c0", in_ready, out_valid, char, mantissa);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    B1 = 8'h01; B2 = 8'h80; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || char !== '0 || mantissa !== '0 || B1_q !== '0 || B2_q !== '0) begin
      errors++; $display("[TB] FAIL abort_clear: ov=%b ir=%b char=%0d mant=%h B1_q=%h expected 0/1/0/0/0", out_valid, in_ready, char, mantissa, B1_q);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send_pair(8'h35, 8'h03, lat);
    checks++;
    if (lat !== 7 || char !== 4'd6 || mantissa !== 9'h114) begin
      errors++; $display("[TB] FAIL abort_recover: lat=%0d char=%0d mant=%h expected 7/6/114", lat, char, mantissa);
    end
    finish_pair();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] b1, b2;
    int k1, k2, f1, f2, s1, s2, lat;
    for (int i = 0; i < 10; i++) begin
      b1 = N'($urandom); b2 = N'($urandom);
      ref_operand(int'(b1), k1, f1, s1);
      ref_operand(int'(b2), k2, f2, s2);
      send_pair(b1, b2, lat);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      checks++;
      if (lat !== 1 + ((s1 > s2) ? s1 : s2) || int'(char) !== k1 + k2 || int'(mantissa) !== (1 << (N - 1)) + f1 + f2 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b%0d (%h,%h): lat=%0d char=%0d mant=%h ir=%b expected %0d/%0d/%h/1", i, b1, b2, lat, char, mantissa, in_ready, 1 + ((s1 > s2) ? s1 : s2), k1 + k2, (1 << (N - 1)) + f1 + f2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
